imem_boot_loader: RTL and testbench

- Sequences the instruction memory at power-up: accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit words, and writes them into consecutive instruction memory words.
- Holds the CPU core in reset while loading and releases it only after the last word has been written.
- Sits between the external byte source (UART RX / debug port) and the instruction memory write port. It replaces the static file preload with a run-time load.

---
 rtl/imem_boot_loader.sv | 140 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Run-time instruction memory loader: packs a byte stream into words,
// writes them to consecutive addresses and holds the core in reset meanwhile.
module imem_boot_loader #(
    parameter int ADDR_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            cpu_rst_n,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            bad_count;

    assign bad_count = (word_count == '0) || (word_count > MAX_WORDS);

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: start handling, little-endian byte packing, word writes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d = word_count;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    word_d  = '0;
                    err_d   = bad_count;
                    state_d = bad_count ? DONE : RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    unique case (bcnt_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        2'd3: word_d[31:24] = rx_data;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d  = 32'({idx_q, 2'b00});
                        wdata_d = {rx_data, word_q[23:0]};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + ONE;
                bcnt_d  = '0;
                word_d  = '0;
                state_d = (idx_q + ONE == count_q) ? DONE : RECV;
            end
        endcase
    end

    // Outputs decoded from the current state; address/data hold between writes.
    always_comb begin
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cpu_rst_n = 1'b0;
        unique case (state_q)
            IDLE:  ;
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
        endcase
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random byte streams with gaps, compared
// against a word-list model built from the loader's packing rules.
module tb_imem_boot_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          we_viol = 0;
    int          rdy_viol = 0;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Record every memory write and any over-long strobe or ready overlap.
    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            if (rx_ready) rdy_viol <= rdy_viol + 1;
            if (we_prev) we_viol <= we_viol + 1;
        end
        we_prev <= mem_we;
    end

    // Reference: word w is bytes 4w..4w+3, little-endian, at byte address 4w.
    function automatic void model_load(input logic [7:0] b[$], input int n);
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(w * 4));
            exp_data.push_back({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
        end
    endfunction

    function automatic int first_diff();
        if (got_addr.size() != exp_addr.size()) return -2;
        for (int i = 0; i < exp_addr.size(); i++)
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                return i;
        return -1;
    endfunction

    function automatic void clear_q();
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endfunction

    task automatic pulse_start(input logic [AW:0] n);
        start = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
        word_count = (AW+1)'($urandom);
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int gap_pct, output bit ok);
        int t;
        ok = 1'b1;
        foreach (b[i]) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = b[i];
            t = 0;
            while (!rx_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!rx_ready) ok = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        #12;
        checks += 8;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b need 0", rx_ready); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_rst_n: got %b need 0", cpu_rst_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b need 0", done); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b need 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        bit ok;
        int d;
        clear_q();
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        model_load(b, 2);
        pulse_start(2);
        send_bytes(b, 0, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL basic_accept: timed out waiting rx_ready"); end
        if (done !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL basic_during_write: done=%b cpu_rst_n=%b need 0 0", done, cpu_rst_n);
        end
        if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin
            errors++; $display("FAIL basic_second_write: we=%b addr=%h need 1 00000004", mem_we, mem_addr);
        end
        @(negedge clk);
        checks += 4;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_release: done=%b cpu_rst_n=%b busy=%b need 1 1 0", done, cpu_rst_n, busy);
        end
        d = first_diff();
        if (d != -1) begin
            errors++; $display("FAIL basic_writes: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
        if (we_viol !== 0) begin errors++; $display("FAIL basic_we_width: %0d long strobes need 0", we_viol); end
        repeat (3) @(negedge clk);
        if (mem_addr !== 32'h4 || mem_wdata !== 32'h00500093) begin
            errors++; $display("FAIL basic_hold: addr=%h data=%h need 00000004 00500093", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b[$];
        bit ok1, ok2, ok3, ok4;
        int d;
        clear_q();
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        model_load(b, 2);
        pulse_start(2);
        send_bytes(b[0:1], 0, ok1);
        repeat (3) @(negedge clk);
        send_bytes(b[2:$], 50, ok2);
        wait_done(ok3);
        checks += 3;
        if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL gaps_timeout: %b%b%b need 111", ok1, ok2, ok3); end
        d = first_diff();
        if (d != -1) begin
            errors++; $display("FAIL gaps_writes: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
        if (rdy_viol !== 0) begin errors++; $display("FAIL gaps_ready_in_write: %0d need 0", rdy_viol); end
        clear_q();
        b = {};
        repeat (12) b.push_back(8'($urandom));
        model_load(b, 3);
        pulse_start(3);
        send_bytes(b, 40, ok1);
        wait_done(ok4);
        checks += 1;
        d = first_diff();
        if (!ok1 || !ok4 || d != -1) begin
            errors++; $display("FAIL gaps_random: %0d writes first_bad=%0d ok=%b%b, need %0d matching", got_addr.size(), d, ok1, ok4, exp_addr.size());
        end
    endtask

    task automatic test_err();
        logic [7:0] b[$];
        logic [AW:0] bad[2];
        bit ok1, ok2;
        int d;
        bad[0] = '0;
        bad[1] = (AW+1)'((1 << AW) + 1);
        foreach (bad[k]) begin
            clear_q();
            pulse_start(bad[k]);
            repeat (2) @(negedge clk);
            checks += 2;
            if (err !== 1'b1 || done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL err_flags[%0d]: err=%b done=%b rst=%b busy=%b need 1 1 1 0", k, err, done, cpu_rst_n, busy);
            end
            if (got_addr.size() !== 0) begin
                errors++; $display("FAIL err_no_write[%0d]: %0d writes need 0", k, got_addr.size());
            end
        end
        clear_q();
        b = {};
        repeat (4) b.push_back(8'($urandom));
        model_load(b, 1);
        pulse_start(1);
        checks += 2;
        if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL err_clear: err=%b busy=%b done=%b rst=%b need 0 1 0 0", err, busy, done, cpu_rst_n);
        end
        send_bytes(b, 20, ok1);
        wait_done(ok2);
        d = first_diff();
        if (!ok1 || !ok2 || d != -1) begin
            errors++; $display("FAIL err_legal_load: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] b[$];
        bit ok1, ok2, ok3;
        int d;
        clear_q();
        b = {};
        repeat (12) b.push_back(8'($urandom));
        model_load(b, 3);
        pulse_start(3);
        send_bytes(b[0:5], 0, ok1);
        pulse_start(1);
        send_bytes(b[6:$], 30, ok2);
        wait_done(ok3);
        checks += 1;
        d = first_diff();
        if (!ok1 || !ok2 || !ok3 || d != -1) begin
            errors++; $display("FAIL ignore_start: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        bit ok1, ok2;
        int d;
        b = '{8'h11, 8'h22};
        pulse_start(2);
        send_bytes(b, 0, ok1);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (rx_ready !== 1'b0 || mem_we !== 1'b0 || cpu_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: rdy=%b we=%b rst=%b busy=%b done=%b err=%b need all 0", rx_ready, mem_we, cpu_rst_n, busy, done, err);
        end
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL midrst_bus: addr=%h data=%h need 0 0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_load(b, 1);
        pulse_start(1);
        send_bytes(b, 0, ok1);
        wait_done(ok2);
        checks += 1;
        d = first_diff();
        if (!ok1 || !ok2 || d != -1 || got_data.size() != 1 || got_data[0] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL midrst_reload: %0d writes first_bad=%0d, need 1 write DDCCBBAA at 0", got_addr.size(), d);
        end
    endtask

    task automatic test_restart();
        logic [7:0] b[$];
        bit ok;
        int d;
        clear_q();
        b = {};
        repeat (4) b.push_back(8'($urandom));
        model_load(b, 1);
        pulse_start(1);
        checks += 4;
        if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL restart_hold: rst=%b done=%b need 0 0", cpu_rst_n, done);
        end
        send_bytes(b, 30, ok);
        if (cpu_rst_n !== 1'b0 || mem_we !== 1'b1) begin
            errors++; $display("FAIL restart_in_write: rst=%b we=%b need 0 1", cpu_rst_n, mem_we);
        end
        @(negedge clk);
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL restart_release: rst=%b need 1", cpu_rst_n); end
        d = first_diff();
        if (!ok || d != -1) begin
            errors++; $display("FAIL restart_writes: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
    endtask

    task automatic test_full();
        logic [7:0] b[$];
        bit ok1, ok2;
        int d;
        int n = 1 << AW;
        clear_q();
        b = {};
        repeat (4 * n) b.push_back(8'($urandom));
        model_load(b, n);
        pulse_start((AW+1)'(n));
        send_bytes(b, 20, ok1);
        wait_done(ok2);
        checks += 3;
        d = first_diff();
        if (!ok1 || !ok2 || d != -1) begin
            errors++; $display("FAIL full_writes: %0d writes first_bad=%0d, need %0d matching", got_addr.size(), d, exp_addr.size());
        end
        if (mem_addr !== 32'((n - 1) * 4)) begin
            errors++; $display("FAIL full_last_addr: got %h need %h", mem_addr, 32'((n - 1) * 4));
        end
        if (we_viol !== 0 || rdy_viol !== 0 || err !== 1'b0) begin
            errors++; $display("FAIL full_protocol: we_viol=%0d rdy_viol=%0d err=%b need 0 0 0", we_viol, rdy_viol, err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        rx_data = '0;
        rx_valid = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_err();
        test_start_ignored();
        test_reset_mid();
        test_restart();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
